// File: rtl/npu_out_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module  : npu_out_drain_pkg
// Brief   : Shared types and default widths for the NPU output drain stage.
// Revision: 1.0 - initial release
// ============================================================================
package npu_out_drain_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int CNT_W_DEF     = 16;
  localparam int RD_LAT_DEF    = 1;
  localparam int BUF_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_e;

endpackage
`default_nettype wire

// File: rtl/npu_out_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : npu_out_skid_buf
// Brief   : Small synchronous circular buffer with push/pop/flush and count.
// Revision: 1.0 - initial release
// ============================================================================
module npu_out_skid_buf #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     npu_rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // A full buffer may still accept a push when the head leaves in the same cycle.
  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge CLK or negedge npu_rst_n) begin
    if (!npu_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/npu_output_drain.sv
`default_nettype none
// ============================================================================
// Module  : npu_output_drain
// Brief   : Pops a programmed number of words from the NPU output FIFO and
//           streams them to the host; optional NPU_OUT_DRAIN_STALL_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module npu_output_drain
  import npu_out_drain_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = RD_LAT_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              npu_rst_n,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic [15:0]       cfg_data_bus,
  input  logic              cfg_count_wr_en,
  input  logic              start,
  input  logic              abort,
  output logic              host_valid,
  input  logic              host_ready,
  output logic [DATA_W-1:0] host_data,
  output logic              host_last,
  output logic              busy,
  output logic              done
`ifdef NPU_OUT_DRAIN_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  drain_state_e      r_state;
  logic [CNT_W-1:0]  r_xfer_count;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_accepted;
  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_last;
  logic [CW-1:0]     w_buf_count;
  logic [CW-1:0]     w_inflight;
  logic [DATA_W:0]   w_head;
  logic              w_accept;
  logic              w_capture;
  logic              w_last_issue;
  logic              w_final_accept;
  logic              w_drained;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CW'(r_tag_vld[i]);
  end

  assign w_accept       = host_valid && host_ready;
  assign w_capture      = r_tag_vld[RD_LAT-1] && !abort;
  assign w_last_issue   = (r_issued == r_xfer_count - CNT_W'(1));
  assign w_final_accept = w_accept && (r_accepted == r_xfer_count - CNT_W'(1));
  assign w_drained      = (w_inflight == '0) && (w_buf_count == '0);

  // Credit check counts words still in the FIFO read pipe against free buffer slots.
  assign fifo_rd_en = (r_state == RUN) && !abort && !fifo_empty &&
                      (r_issued < r_xfer_count) &&
                      ((w_buf_count + w_inflight) < CW'(BUF_DEPTH));

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

  npu_out_skid_buf #(
    .WIDTH (DATA_W + 1),
    .DEPTH (BUF_DEPTH)
  ) u_skid_buf (
    .CLK       (CLK),
    .npu_rst_n (npu_rst_n),
    .flush     (abort),
    .push      (w_capture),
    .push_data ({r_tag_last[RD_LAT-1], fifo_dout}),
    .pop       (w_accept),
    .head_data (w_head),
    .count     (w_buf_count)
  );

  assign host_valid             = (w_buf_count != '0);
  assign {host_last, host_data} = w_head;

  always_ff @(posedge CLK or negedge npu_rst_n) begin
    if (!npu_rst_n) begin
      r_state      <= IDLE;
      r_xfer_count <= '0;
      r_issued     <= '0;
      r_accepted   <= '0;
      r_tag_vld    <= '0;
      r_tag_last   <= '0;
    end else if (abort) begin
      r_state    <= IDLE;
      r_tag_vld  <= '0;
      r_tag_last <= '0;
    end else begin
      r_tag_vld  <= (r_tag_vld << 1) | RD_LAT'(fifo_rd_en);
      r_tag_last <= (r_tag_last << 1) | RD_LAT'(fifo_rd_en && w_last_issue);
      if (fifo_rd_en) r_issued <= r_issued + CNT_W'(1);
      if (w_accept && (r_accepted != r_xfer_count)) r_accepted <= r_accepted + CNT_W'(1);
      case (r_state)
        IDLE: begin
          if (cfg_count_wr_en) r_xfer_count <= cfg_data_bus[CNT_W-1:0];
          if (start) begin
            r_issued   <= '0;
            r_accepted <= '0;
            r_state    <= (r_xfer_count == '0) ? DONE : RUN;
          end
        end
        RUN:     if (r_issued == r_xfer_count) r_state <= FLUSH;
        FLUSH:   if (w_final_accept || w_drained) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef NPU_OUT_DRAIN_STALL_CNT_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge CLK or negedge npu_rst_n) begin
    if (!npu_rst_n) begin
      r_stall_cycles <= '0;
    end else if ((r_state == IDLE) && start && !abort) begin
      r_stall_cycles <= '0;
    end else if (host_valid && !host_ready && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_npu_output_drain.sv
`default_nettype none
// ============================================================================
// Module  : tb_npu_output_drain
// Brief   : Self-checking bench: FIFO/host environment plus stream reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_npu_output_drain;
  localparam int DATA_W    = 32;
  localparam int RD_LAT    = 1;
  localparam int BUF_DEPTH = 4;

  logic              CLK = 1'b0;
  logic              npu_rst_n = 1'b0;
  logic              fifo_empty = 1'b1;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic [15:0]       cfg_data_bus = '0;
  logic              cfg_count_wr_en = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              host_valid;
  logic              host_ready = 1'b0;
  logic [DATA_W-1:0] host_data;
  logic              host_last;
  logic              busy;
  logic              done;
`ifdef NPU_OUT_DRAIN_STALL_CNT_EN
  logic [15:0]       stall_cycles;
`endif

  npu_output_drain u_dut (
    .CLK             (CLK),
    .npu_rst_n       (npu_rst_n),
    .fifo_empty      (fifo_empty),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_dout       (fifo_dout),
    .cfg_data_bus    (cfg_data_bus),
    .cfg_count_wr_en (cfg_count_wr_en),
    .start           (start),
    .abort           (abort),
    .host_valid      (host_valid),
    .host_ready      (host_ready),
    .host_data       (host_data),
    .host_last       (host_last),
    .busy            (busy),
    .done            (done)
`ifdef NPU_OUT_DRAIN_STALL_CNT_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Environment: output FIFO with a one-cycle read latency, junk on idle cycles.
  logic [DATA_W-1:0] fifo_q[$];
  bit   hold_empty = 1'b0;
  int   empty_pct = 0;
  int   ready_mode = 2;
  int   cyc = 0;
  int   pop_cnt, pop_empty_err, first_pop_cyc, last_pop_cyc;

  always @(posedge CLK) begin
    if (fifo_rd_en && !fifo_empty && (fifo_q.size() != 0)) begin
      fifo_dout <= fifo_q.pop_front();
      if (pop_cnt == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      pop_cnt++;
    end else begin
      if (fifo_rd_en) pop_empty_err++;
      fifo_dout <= $urandom;
    end
  end

  // Host-side monitor, sampled mid-cycle.
  logic [DATA_W:0] rx_q[$];
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] prev_word;
  bit   prev_stall, prev_done, busy_after_done;
  int   acc_cnt, done_cnt, done_cyc, last_acc_cyc, hold_err, stall_obs, out_max;

  always @(negedge CLK) begin
    cyc++;
    fifo_empty = hold_empty || (fifo_q.size() == 0);
    if (prev_stall && npu_rst_n &&
        !(host_valid && ({host_last, host_data} === prev_word))) hold_err++;
    prev_stall = npu_rst_n && host_valid && !host_ready && !abort;
    prev_word  = {host_last, host_data};
    if (host_valid && !host_ready) stall_obs++;
    if (host_valid && host_ready) begin
      rx_q.push_back({host_last, host_data});
      acc_cnt++;
      last_acc_cyc = cyc;
    end
    if (prev_done) busy_after_done = busy;
    prev_done = done;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (pop_cnt - acc_cnt > out_max) out_max = pop_cnt - acc_cnt;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    case (ready_mode)
      0:       host_ready = 1'b1;
      1:       host_ready = 1'($urandom_range(0, 1));
      default: host_ready = 1'b0;
    endcase
    hold_empty = (empty_pct != 0) && ($urandom_range(0, 99) < empty_pct);
  endtask

  task automatic clear_stats();
    pop_cnt = 0; pop_empty_err = 0; acc_cnt = 0; done_cnt = 0; hold_err = 0;
    stall_obs = 0; out_max = 0; done_cyc = -1; last_acc_cyc = -1;
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic load_fifo(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back($urandom);
  endtask

  // Reference stream: the next cnt FIFO words in order, last flag on the final one.
  function automatic void build_exp(input int cnt);
    exp_q.delete();
    for (int i = 0; i < cnt; i++) exp_q.push_back({(i == cnt - 1), fifo_q[i]});
  endfunction

  task automatic start_xfer(input int cnt);
    tick();
    cfg_data_bus = 16'(cnt);
    cfg_count_wr_en = 1'b1;
    tick();
    cfg_count_wr_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done_cnt > d0) ok = 1'b1;
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    npu_rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({fifo_rd_en, host_valid, host_last, busy, done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=00000", {fifo_rd_en, host_valid, host_last, busy, done});
    end
    total++;
    if (host_data !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", host_data);
    end
`ifdef NPU_OUT_DRAIN_STALL_CNT_EN
    total++;
    if (stall_cycles !== 16'd0) begin
      bad++;
      $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
    end
`endif
    npu_rst_n = 1'b1;
    tick();
    tick();
    total++;
    if ({busy, host_valid, fifo_rd_en} !== 3'b0) begin
      bad++;
      $display("FAIL reset_idle got=%b exp=000", {busy, host_valid, fifo_rd_en});
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_stats();
    fifo_q.delete();
    load_fifo(4);
    build_exp(4);
    ready_mode = 0;
    start_xfer(4);
    wait_done(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout got=0 exp=1"); end
    total++;
    if (rx_q.size() != 4) begin bad++; $display("FAIL basic_len got=%0d exp=4", rx_q.size()); end
    foreach (exp_q[i]) if (i < rx_q.size()) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL basic_word[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
    total++;
    if (pop_cnt != 4 || last_pop_cyc - first_pop_cyc != 3) begin
      bad++;
      $display("FAIL basic_b2b_pops got=%0d/%0d exp=4/3", pop_cnt, last_pop_cyc - first_pop_cyc);
    end
    total++;
    if (done_cyc - last_acc_cyc != 1) begin
      bad++;
      $display("FAIL basic_done_lat got=%0d exp=1", done_cyc - last_acc_cyc);
    end
    total++;
    if (busy_after_done !== 1'b0 || done_cnt != 1) begin
      bad++;
      $display("FAIL basic_done_busy got=%b/%0d exp=0/1", busy_after_done, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_stats();
    fifo_q.delete();
    load_fifo(8);
    build_exp(8);
    ready_mode = 2;
    start_xfer(8);
    for (int i = 0; i < 20 && !host_valid; i++) tick();
    // Attempt to reprogram the count mid-transfer; it must not take effect.
    cfg_data_bus = 16'd1;
    cfg_count_wr_en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      tick();
      cfg_count_wr_en = 1'b0;
    end
    total++;
    if (pop_cnt < BUF_DEPTH - RD_LAT || pop_cnt > BUF_DEPTH) begin
      bad++;
      $display("FAIL bp_pops got=%0d exp=%0d..%0d", pop_cnt, BUF_DEPTH - RD_LAT, BUF_DEPTH);
    end
    ready_mode = 0;
    tick();
    wait_done(200, ok);
    total++;
    if (!ok || rx_q.size() != 8) begin
      bad++;
      $display("FAIL bp_len got=%0d/%0d exp=1/8", ok, rx_q.size());
    end
    foreach (exp_q[i]) if (i < rx_q.size()) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL bp_word[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
    total++;
    if (out_max > BUF_DEPTH || hold_err != 0 || stall_obs != 20) begin
      bad++;
      $display("FAIL bp_flow got=out%0d/hold%0d/stall%0d exp=<=%0d/0/20", out_max, hold_err, stall_obs, BUF_DEPTH);
    end
`ifdef NPU_OUT_DRAIN_STALL_CNT_EN
    total++;
    if (stall_cycles !== 16'd20) begin
      bad++;
      $display("FAIL bp_stall_cnt got=%0d exp=20", stall_cycles);
    end
`endif
  endtask

  task automatic test_empty_wait();
    bit ok;
    logic [DATA_W-1:0] w;
    clear_stats();
    fifo_q.delete();
    ready_mode = 0;
    start_xfer(3);
    repeat (10) tick();
    total++;
    if (pop_cnt != 0 || pop_empty_err != 0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL empty_nopop got=%0d/%0d/%b exp=0/0/1", pop_cnt, pop_empty_err, busy);
    end
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      exp_q.push_back({(i == 2), w});
    end
    wait_done(200, ok);
    total++;
    if (!ok || rx_q.size() != 3) begin
      bad++;
      $display("FAIL empty_len got=%0d/%0d exp=1/3", ok, rx_q.size());
    end
    foreach (exp_q[i]) if (i < rx_q.size()) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL empty_word[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_count();
    clear_stats();
    load_fifo(2);
    ready_mode = 0;
    start_xfer(0);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b exp=1", done); end
    tick();
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL zero_after got=%b exp=00", {done, busy}); end
    repeat (3) tick();
    total++;
    if (pop_cnt != 0 || pop_empty_err != 0 || done_cnt != 1) begin
      bad++;
      $display("FAIL zero_nopop got=%0d/%0d exp=0/1", pop_cnt, done_cnt);
    end
  endtask

  task automatic test_abort();
    bit ok;
    clear_stats();
    fifo_q.delete();
    load_fifo(12);
    ready_mode = 0;
    start_xfer(6);
    for (int i = 0; i < 50 && acc_cnt < 2; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({busy, host_valid} !== 2'b00) begin
      bad++;
      $display("FAIL abort_idle got=%b exp=00", {busy, host_valid});
    end
    repeat (4) tick();
    total++;
    if (host_valid !== 1'b0 || done_cnt != 0 || fifo_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet got=%b/%0d exp=0/0", host_valid, done_cnt);
    end
    clear_stats();
    build_exp(2);
    start_xfer(2);
    wait_done(200, ok);
    total++;
    if (!ok || rx_q.size() != 2 || done_cnt != 1) begin
      bad++;
      $display("FAIL abort_restart got=%0d/%0d/%0d exp=1/2/1", ok, rx_q.size(), done_cnt);
    end
    foreach (exp_q[i]) if (i < rx_q.size()) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL abort_word[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int cnt;
    for (int it = 0; it < 6; it++) begin
      clear_stats();
      cnt = $urandom_range(1, 12);
      if (fifo_q.size() < cnt) load_fifo(cnt - fifo_q.size() + $urandom_range(0, 3));
      build_exp(cnt);
      ready_mode = 1;
      empty_pct = 30;
      start_xfer(cnt);
      wait_done(400, ok);
      ready_mode = 0;
      empty_pct = 0;
      total++;
      if (!ok || rx_q.size() != cnt || done_cnt != 1) begin
        bad++;
        $display("FAIL rand%0d_len got=%0d/%0d/%0d exp=1/%0d/1", it, ok, rx_q.size(), done_cnt, cnt);
      end
      foreach (exp_q[i]) if (i < rx_q.size()) begin
        total++;
        if (rx_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL rand%0d_word[%0d] got=%h exp=%h", it, i, rx_q[i], exp_q[i]);
        end
      end
      total++;
      if (out_max > BUF_DEPTH || hold_err != 0 || pop_empty_err != 0) begin
        bad++;
        $display("FAIL rand%0d_flow got=%0d/%0d/%0d exp=<=%0d/0/0", it, out_max, hold_err, pop_empty_err, BUF_DEPTH);
      end
    end
  endtask

  task automatic test_async_reset();
    clear_stats();
    load_fifo(8);
    ready_mode = 2;
    start_xfer(8);
    repeat (4) tick();
    total++;
    if ({busy, host_valid} !== 2'b11) begin
      bad++;
      $display("FAIL arst_pre got=%b exp=11", {busy, host_valid});
    end
    @(posedge CLK);
    #3;
    npu_rst_n = 1'b0;
    #1;
    total++;
    if ({fifo_rd_en, host_valid, host_last, busy, done} !== 5'b0 || host_data !== '0) begin
      bad++;
      $display("FAIL arst_outputs got=%b/%h exp=00000/0", {fifo_rd_en, host_valid, host_last, busy, done}, host_data);
    end
    @(negedge CLK);
    #2;
    npu_rst_n = 1'b1;
    ready_mode = 0;
    tick();
    tick();
    total++;
    if ({busy, host_valid} !== 2'b00) begin
      bad++;
      $display("FAIL arst_idle got=%b exp=00", {busy, host_valid});
    end
    fifo_q.delete();
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_wait();
    test_zero_count();
    test_abort();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
